// File: rtl/swire_link_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : swire_link_arbiter_pkg
//  Description : Shared types, default timings and helpers for the single-wire
//                link arbiter and its receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package swire_link_arbiter_pkg;

    // Default bus timings, in clk cycles
    localparam int DEF_NREQ    = 2;
    localparam int DEF_T_SHORT = 8;
    localparam int DEF_T_LONG  = 24;
    localparam int DEF_T_GAP   = 16;
    localparam int DEF_T_IDLE  = 64;
    localparam int DEF_CNT_W   = 16;

    // GAP cycles 0..SETTLE_CYCLES-1 are ignored while our own release propagates
    // back through the synchroniser.
    localparam int SETTLE_CYCLES = 3;

    // Shortest low pulse accepted as a bit; anything narrower is a glitch
    localparam int MIN_PULSE = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    // Decision threshold between a short (0) and long (1) low pulse
    function automatic int bit_threshold(input int t_short, input int t_long);
        return (t_short + t_long) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/swire_link_arbiter_rx.sv
`default_nettype none
// ============================================================================
//  Module      : swire_link_arbiter_rx
//  Description : Always-on receiver: line synchroniser, bus-idle counter and
//                pulse-width bit decoder for everything seen on the wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module swire_link_arbiter_rx
    import swire_link_arbiter_pkg::*;
#(
    parameter int T_SHORT = DEF_T_SHORT,
    parameter int T_LONG  = DEF_T_LONG,
    parameter int T_IDLE  = DEF_T_IDLE,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_in,
    output logic       line_s,
    output logic       bus_free,
    output logic       rx_valid,
    output logic [7:0] rx_data
);

    localparam logic [CNT_W-1:0] C_TH     = CNT_W'(bit_threshold(T_SHORT, T_LONG));
    localparam logic [CNT_W-1:0] C_IDLE   = CNT_W'(T_IDLE);
    localparam logic [CNT_W-1:0] C_MAX    = '1;
    localparam logic [CNT_W-1:0] C_GLITCH = CNT_W'(MIN_PULSE);

    logic             line_meta;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [7:0]       shift;
    logic [2:0]       nbits;
    logic             pulse_bit;

    assign bus_free  = (idle_cnt == C_IDLE);
    assign pulse_bit = (low_cnt >= C_TH);

    // Two-flop synchroniser; resets to the released (pulled-up) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_meta <= 1'b1;
            line_s    <= 1'b1;
        end else begin
            line_meta <= line_in;
            line_s    <= line_meta;
        end
    end

    // Consecutive-high counter, saturating at the bus-free mark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!line_s) begin
            idle_cnt <= '0;
        end else if (idle_cnt != C_IDLE) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Measure each low pulse, classify it on the rising edge, assemble bytes MSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt  <= '0;
            shift    <= '0;
            nbits    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (!line_s) begin
                if (low_cnt != C_MAX) begin
                    low_cnt <= low_cnt + 1'b1;
                end
            end else begin
                low_cnt <= '0;
                if (low_cnt >= C_GLITCH) begin
                    shift <= {shift[6:0], pulse_bit};
                    nbits <= nbits + 3'd1;
                    if (nbits == 3'd7) begin
                        rx_valid <= 1'b1;
                        rx_data  <= {shift[6:0], pulse_bit};
                    end
                end else if (bus_free) begin
                    // A long idle ends any frame: drop a partial byte
                    nbits <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/swire_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : swire_link_arbiter
//  Description : Round-robin arbiter sharing one open-drain pulse-width coded
//                wire between NREQ byte senders, with collision detection and
//                a concurrent receiver of all wire traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module swire_link_arbiter
    import swire_link_arbiter_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int T_SHORT = DEF_T_SHORT,
    parameter int T_LONG  = DEF_T_LONG,
    parameter int T_GAP   = DEF_T_GAP,
    parameter int T_IDLE  = DEF_T_IDLE,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic              done,
    output logic              lost,
    output logic              busy,
    input  logic              line_in,
    output logic              line_drive_low,
    output logic              rx_valid,
    output logic [7:0]        rx_data
);

    localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] C_GAP_END = CNT_W'(T_GAP - 1);

    arb_state_t       state;
    logic [RR_W-1:0]  rr;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] low_len;
    logic [RR_W-1:0]  pick_idx;
    logic             pick_ok;
    logic             line_s;
    logic             bus_free;

    swire_link_arbiter_rx #(
        .T_SHORT (T_SHORT),
        .T_LONG  (T_LONG),
        .T_IDLE  (T_IDLE),
        .CNT_W   (CNT_W)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (line_in),
        .line_s   (line_s),
        .bus_free (bus_free),
        .rx_valid (rx_valid),
        .rx_data  (rx_data)
    );

    // Last cycle index of the current low pulse
    assign low_len = shreg[7] ? CNT_W'(T_LONG - 1) : CNT_W'(T_SHORT - 1);

    // Round-robin search: first active request after the last winner
    always_comb begin
        int idx;
        idx      = 0;
        pick_idx = '0;
        pick_ok  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr) + k) % NREQ;
            if (req[idx]) begin
                pick_idx = RR_W'(idx);
                pick_ok  = 1'b1;
            end
        end
    end

    // Arbitration and bit-transmit state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rr             <= RR_W'(NREQ - 1);
            shreg          <= '0;
            bit_cnt        <= '0;
            tcnt           <= '0;
            grant          <= '0;
            done           <= 1'b0;
            lost           <= 1'b0;
            busy           <= 1'b0;
            line_drive_low <= 1'b0;
        end else begin
            done <= 1'b0;
            lost <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus_free && (|req)) begin
                        state <= ST_ARB;
                        busy  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (!pick_ok) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        grant          <= NREQ'(1) << pick_idx;
                        rr             <= pick_idx;
                        shreg          <= req_data[8*int'(pick_idx) +: 8];
                        bit_cnt        <= 3'd7;
                        tcnt           <= '0;
                        line_drive_low <= 1'b1;
                        state          <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tcnt == low_len) begin
                        line_drive_low <= 1'b0;
                        tcnt           <= '0;
                        state          <= ST_GAP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if ((tcnt >= C_SETTLE) && !line_s) begin
                        // Someone else is holding the wire low: back off
                        lost  <= 1'b1;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (tcnt == C_GAP_END) begin
                        if (bit_cnt == 3'd0) begin
                            done  <= 1'b1;
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            bit_cnt        <= bit_cnt - 3'd1;
                            shreg          <= {shreg[6:0], 1'b0};
                            tcnt           <= '0;
                            line_drive_low <= 1'b1;
                            state          <= ST_LOW;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_swire_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swire_link_arbiter
//  Description : Self-checking bench for swire_link_arbiter: local bytes with
//                random requests and data, collisions, external traffic,
//                partial frames, glitches and mid-bit reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swire_link_arbiter;

    localparam int NREQ = 2;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [15:0]     req_data;
    logic [NREQ-1:0] grant;
    logic            done;
    logic            lost;
    logic            busy;
    logic            line_drive_low;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            ext_drive;
    logic            line;

    // Wired-AND open-drain wire with external pull-up
    assign line = !(line_drive_low || ext_drive);

    swire_link_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_data       (req_data),
        .grant          (grant),
        .done           (done),
        .lost           (lost),
        .busy           (busy),
        .line_in        (line),
        .line_drive_low (line_drive_low),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int exp_rr      = NREQ - 1;
    int hi_run      = 0;
    int last_hi     = 0;
    int done_cnt    = 0;
    bit grant_seen  = 0;
    logic [7:0] rx_q[$];

    // Wire/receiver observers, updated on the falling edge before the main thread samples
    always @(negedge clk) begin
        if (line) begin
            hi_run++;
        end else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0;
        end
        if (rx_valid) rx_q.push_back(rx_data);
        if (done) done_cnt++;
        if (grant != 0) grant_seen = 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Round-robin reference: first set request after the previous winner
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int rr);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic wait_grant(input logic [NREQ-1:0] mask);
        int n;
        int ei;
        n = 0;
        tick();
        while (grant == 0 && n < 800) begin
            tick();
            n++;
        end
        ei = rr_pick(mask, exp_rr);
        chk("grant", grant, 32'(1) << ei);
        chk("idle_before_grant", (last_hi >= 64), 1);
        chk("busy_granted", busy, 1);
        exp_rr = ei;
    endtask

    // Local byte: check grant, every pulse width and gap, done, and the decoded byte
    task automatic local_byte(input logic [NREQ-1:0] mask, input logic [7:0] d0,
                              input logic [7:0] d1, input bit drop);
        logic [7:0] d;
        int w;
        int g;
        req_data = {d1, d0};
        req      = mask;
        wait_grant(mask);
        d = (exp_rr == 1) ? d1 : d0;
        if (drop) req = '0;
        for (int b = 7; b >= 0; b--) begin
            w = 0;
            while (line == 1'b0 && w < 100) begin
                w++;
                tick();
            end
            chk("bit_width", w, d[b] ? 24 : 8);
            g = 0;
            if (b != 0) begin
                while (line == 1'b1 && g < 100) begin
                    g++;
                    tick();
                end
                chk("gap", g, 16);
            end else begin
                while (done == 1'b0 && g < 100) begin
                    g++;
                    tick();
                end
                chk("last_gap", g, 16);
                chk("done", done, 1);
                chk("lost_clear", lost, 0);
                chk("grant_fall", grant, 0);
            end
        end
        tick();
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("rx_count", rx_q.size(), 1);
        if (rx_q.size() != 0) chk("rx_data", rx_q.pop_front(), d);
        req = '0;
    endtask

    // External sender driving the wire with the same coding
    task automatic ext_send(input logic [7:0] d, input int nbits);
        for (int b = 7; b > 7 - nbits; b--) begin
            ext_drive = 1'b1;
            repeat (d[b] ? 24 : 8) tick();
            ext_drive = 1'b0;
            repeat (16) tick();
        end
    endtask

    initial begin
        int n;
        int pulses;
        int dc;
        logic prev;
        logic [7:0] d;
        bit seen_lost;

        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        ext_drive = 1'b0;
        repeat (3) tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_lost", lost, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drive", line_drive_low, 0);
        chk("rst_rx_valid", rx_valid, 0);
        rst_n = 1'b1;

        // Directed first byte
        local_byte(2'b01, 8'hA5, 8'h00, 1'b0);

        // Both requesters held: grants must alternate
        for (int i = 0; i < 3; i++) local_byte(2'b11, 8'($urandom), 8'($urandom), 1'b0);

        // Random requests, data, and early request drops
        for (int i = 0; i < 5; i++) begin
            local_byte(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom),
                       1'($urandom_range(0, 1)));
        end

        // Collision: external pull-down 5 cycles into the first gap
        req_data = {8'h00, 8'($urandom)};
        req      = 2'b01;
        wait_grant(2'b01);
        n = 0;
        while (line == 1'b0 && n < 100) begin
            n++;
            tick();
        end
        repeat (5) tick();
        dc        = done_cnt;
        seen_lost = 0;
        ext_drive = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (lost && !seen_lost) begin
                seen_lost = 1;
                chk("lost_grant", grant, 0);
                chk("lost_busy", busy, 0);
                req = '0;
            end
            tick();
        end
        chk("lost_seen", seen_lost, 1);
        chk("lost_released", line_drive_low, 0);
        ext_drive = 1'b0;
        req       = '0;
        repeat (100) tick();
        chk("lost_no_done", done_cnt, dc);
        chk("lost_partial_dropped", rx_q.size(), 0);

        // External byte with no local request
        grant_seen = 0;
        ext_send(8'h3C, 8);
        repeat (10) tick();
        chk("ext_rx_count", rx_q.size(), 1);
        if (rx_q.size() != 0) chk("ext_rx_data", rx_q.pop_front(), 8'h3C);
        chk("ext_no_grant", grant_seen, 0);

        // Partial frame discarded by idle, a glitch ignored, then a full byte
        ext_send(8'($urandom), 5);
        repeat (80) tick();
        chk("partial_no_rx", rx_q.size(), 0);
        ext_drive = 1'b1;
        tick();
        ext_drive = 1'b0;
        repeat (20) tick();
        ext_send(8'h81, 8);
        repeat (10) tick();
        chk("after_partial_count", rx_q.size(), 1);
        if (rx_q.size() != 0) chk("after_partial_data", rx_q.pop_front(), 8'h81);

        // Reset during the low pulse of bit 3 (a long pulse)
        req_data = {8'h00, 8'h0F};
        req      = 2'b01;
        wait_grant(2'b01);
        pulses = 1;
        prev   = 1'b0;
        n      = 0;
        while (pulses < 5 && n < 3000) begin
            tick();
            if (prev && !line) pulses++;
            prev = line;
            n++;
        end
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_drive", line_drive_low, 0);
        chk("rst_mid_wire", line, 1);
        req = '0;
        tick();
        rst_n  = 1'b1;
        exp_rr = NREQ - 1;
        tick();
        chk("rst_mid_grant", grant, 0);
        chk("rst_mid_busy", busy, 0);
        rx_q.delete();
        local_byte(2'b11, 8'($urandom), 8'($urandom), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
